// File: rtl/lite_cpu_pkg.sv
// rtl/lite_cpu_pkg.sv - shared fetch state encoding and opcode length decode
package lite_cpu_pkg;

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DRAIN = 2'd3
  } fetch_state_e;

  localparam int LEN_MSB = 7;
  localparam int LEN_LSB = 6;

  // Length field 00 -> 1 byte, 01 -> 2 bytes, 1x -> 3 bytes.
  function automatic logic [1:0] len_of(input logic [7:0] opcode);
    logic [1:0] len;
    case (opcode[LEN_MSB:LEN_LSB])
      2'b00:   len = 2'd1;
      2'b01:   len = 2'd2;
      default: len = 2'd3;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/fetch_len_decode.sv
// rtl/fetch_len_decode.sv - combinational opcode to instruction length
module fetch_len_decode
  import lite_cpu_pkg::*;
(
  input  logic [7:0] opcode,
  output logic [1:0] instr_len
);

  assign instr_len = len_of(opcode);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - byte-serial instruction fetch and assembly from program ROM
// One ROM read outstanding at a time; jumps flush partial and in-flight fetches.
module fetch_unit
  import lite_cpu_pkg::*;
#(
  parameter int                   size_addr = 8,
  parameter logic [size_addr-1:0] reset_pc  = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  output logic                 rom_read,
  output logic [size_addr-1:0] rom_address,
  input  logic                 rom_ready,
  input  logic [7:0]           rom_data,
  output logic                 instr_valid,
  input  logic                 instr_ready,
  output logic [23:0]          instr,
  output logic [1:0]           instr_len,
  output logic [size_addr-1:0] instr_pc,
  input  logic                 jump,
  input  logic [size_addr-1:0] jump_addr
);

  localparam logic [size_addr-1:0] PcOne = size_addr'(1);

  fetch_state_e         state_q, state_d;
  logic [size_addr-1:0] pc_q, pc_d;
  logic [size_addr-1:0] instr_pc_q, instr_pc_d;
  logic [1:0]           byte_idx_q, byte_idx_d;
  logic [1:0]           len_q, len_d;
  logic [23:0]          instr_q, instr_d;
  logic [1:0]           dec_len;
  logic [1:0]           eff_len;
  logic                 last_byte;
  logic                 capture;

  fetch_len_decode u_len_decode (
    .opcode    (rom_data),
    .instr_len (dec_len)
  );

  // On the opcode byte the stored length is stale, so use the fresh decode.
  assign eff_len   = (byte_idx_q == 2'd0) ? dec_len : len_q;
  assign last_byte = ({1'b0, byte_idx_q} + 3'd1) >= {1'b0, eff_len};
  assign capture   = (state_q == S_WAIT) && rom_ready && !jump;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ:   state_d = S_WAIT;
      S_WAIT:  if (rom_ready) state_d = last_byte ? S_HOLD : S_REQ;
      S_HOLD:  if (instr_ready) state_d = S_REQ;
      S_DRAIN: if (rom_ready) state_d = S_REQ;
      default: state_d = S_REQ;
    endcase
    // A read already on its way to the ROM must be drained before reissuing.
    if (jump) begin
      case (state_q)
        S_REQ:   state_d = S_DRAIN;
        S_WAIT:  state_d = rom_ready ? S_REQ : S_DRAIN;
        S_HOLD:  state_d = S_REQ;
        S_DRAIN: state_d = rom_ready ? S_REQ : S_DRAIN;
        default: state_d = S_REQ;
      endcase
    end
  end

  always_comb begin
    rom_read    = (state_q == S_REQ);
    instr_valid = (state_q == S_HOLD);
  end

  always_comb begin
    pc_d       = pc_q;
    byte_idx_d = byte_idx_q;
    instr_d    = instr_q;
    len_d      = len_q;
    instr_pc_d = instr_pc_q;
    if (jump) begin
      pc_d       = jump_addr;
      byte_idx_d = 2'd0;
    end else if (capture) begin
      pc_d = pc_q + PcOne;
      case (byte_idx_q)
        2'd0: begin
          instr_d    = {16'h0000, rom_data};
          instr_pc_d = pc_q;
          len_d      = dec_len;
        end
        2'd1:    instr_d[15:8]  = rom_data;
        default: instr_d[23:16] = rom_data;
      endcase
      byte_idx_d = last_byte ? 2'd0 : byte_idx_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= reset_pc;
      byte_idx_q <= 2'd0;
      instr_q    <= 24'h000000;
      len_q      <= 2'd0;
      instr_pc_q <= '0;
    end else begin
      pc_q       <= pc_d;
      byte_idx_q <= byte_idx_d;
      instr_q    <= instr_d;
      len_q      <= len_d;
      instr_pc_q <= instr_pc_d;
    end
  end

  assign rom_address = pc_q;
  assign instr       = instr_q;
  assign instr_len   = len_q;
  assign instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a behavioural ROM
module tb_fetch_unit;

  typedef struct {
    logic [7:0]  pc;
    logic [1:0]  len;
    logic [23:0] instr;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rom_read;
  logic [7:0]  rom_address;
  logic        rom_ready = 1'b0;
  logic [7:0]  rom_data = 8'h00;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [23:0] instr;
  logic [1:0]  instr_len;
  logic [7:0]  instr_pc;
  logic        jump = 1'b0;
  logic [7:0]  jump_addr = 8'h00;

  logic [7:0] rom [256];
  exp_t       exp_q [$];
  logic [7:0] next_pc = 8'h00;
  int         checks = 0;
  int         errors = 0;
  int         accepted = 0;
  int         cyc = 0;
  int         rom_lat_max = 0;
  int         rom_force_dly = -1;

  bit         pend = 1'b0;
  logic [7:0] pend_addr;
  int         pend_dly;

  fetch_unit #(.size_addr(8), .reset_pc(8'h00)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rom_read    (rom_read),
    .rom_address (rom_address),
    .rom_ready   (rom_ready),
    .rom_data    (rom_data),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .instr_len   (instr_len),
    .instr_pc    (instr_pc),
    .jump        (jump),
    .jump_addr   (jump_addr)
  );

  always #5 clk = ~clk;

  // Reference: an instruction is its opcode plus the following bytes, addresses wrapping.
  function automatic exp_t model_instr(input logic [7:0] a);
    exp_t e;
    int   n;
    n = (rom[a] < 8'h40) ? 1 : (rom[a] < 8'h80) ? 2 : 3;
    e.pc    = a;
    e.len   = 2'(n);
    e.instr = 24'h0;
    for (int k = 0; k < n; k++) e.instr[8*k +: 8] = rom[8'(a + 8'(k))];
    return e;
  endfunction

  task automatic refill();
    exp_t e;
    if (exp_q.size() == 0) begin
      e = model_instr(next_pc);
      exp_q.push_back(e);
      next_pc = 8'(next_pc + 8'(e.len));
    end
  endtask

  task automatic restart_model(input logic [7:0] a);
    exp_q.delete();
    next_pc = a;
    refill();
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    jump = 1'b0;
    cyc++;
    refill();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic wait_valid(output int waited);
    waited = 0;
    do begin
      step();
      waited++;
    end while (!instr_valid && waited < 60);
    if (!instr_valid) begin
      checks++;
      errors++;
      $display("FAIL wait_valid: instr_valid still 0 after %0d cycles", waited);
    end
  endtask

  task automatic issue_jump(input logic [7:0] a);
    exp_t h;
    jump      = 1'b1;
    jump_addr = a;
    if (instr_valid && instr_ready && exp_q.size() > 0) begin
      h = exp_q[0];
      exp_q.delete();
      exp_q.push_back(h);
      next_pc = a;
    end else begin
      restart_model(a);
    end
  endtask

  // Byte-wide ROM: answers each read after 1 + delay cycles, flags overlapping reads.
  always begin
    bit busy;
    @(posedge clk);
    #1;
    busy      = pend;
    rom_ready = 1'b0;
    rom_data  = 8'($urandom);
    if (pend) begin
      if (pend_dly == 0) begin
        rom_ready = 1'b1;
        rom_data  = rom[pend_addr];
        pend      = 1'b0;
      end else begin
        pend_dly--;
      end
    end
    if (rom_read) begin
      if (rst_n) begin
        checks++;
        if (busy) begin
          errors++;
          $display("FAIL rom_overlap: rom_read=1 with a read outstanding (cycle %0d)", cyc);
        end
      end
      pend      = 1'b1;
      pend_addr = rom_address;
      pend_dly  = (rom_force_dly >= 0) ? rom_force_dly : int'($urandom_range(0, rom_lat_max));
      rom_force_dly = -1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && instr_valid && instr_ready) begin
      checks++;
      accepted++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard: unexpected instr %h pc %h len %0d", instr, instr_pc, instr_len);
      end else begin
        e = exp_q.pop_front();
        if ({instr, instr_len, instr_pc} !== {e.instr, e.len, e.pc}) begin
          errors++;
          $display("FAIL scoreboard: got instr %h len %0d pc %h expected instr %h len %0d pc %h",
                   instr, instr_len, instr_pc, e.instr, e.len, e.pc);
        end
      end
    end
  end

  initial begin
    int w;
    int t0;
    for (int i = 0; i < 256; i++) rom[i] = 8'($urandom);
    rom[8'h00] = 8'h05;
    rom[8'h01] = 8'h47; rom[8'h02] = 8'h12;
    rom[8'h03] = 8'h8A; rom[8'h04] = 8'h34; rom[8'h05] = 8'h56;
    rom[8'h06] = 8'hC0; rom[8'h07] = 8'h11; rom[8'h08] = 8'h22;
    rom[8'h40] = 8'h15;
    instr_ready = 1'b1;

    step(); step();
    check("reset_valid", instr_valid, 0);
    check("reset_instr", instr, 0);
    check("reset_len", instr_len, 0);
    check("reset_pc", instr_pc, 0);
    check("reset_addr", rom_address, 8'h00);
    step();
    restart_model(8'h00);
    rst_n = 1'b1;
    t0 = cyc;
    check("c0_rom_read", rom_read, 1);
    check("c0_addr", rom_address, 8'h00);
    step();
    check("c1_valid", instr_valid, 0);
    check("c1_rom_read", rom_read, 0);
    step();
    check("c2_valid", instr_valid, 1);
    check("c2_instr", instr, 24'h000005);
    check("c2_len", instr_len, 1);
    check("c2_pc", instr_pc, 8'h00);

    wait_valid(w);
    check("lat_2byte", w, 5);
    check("i2_instr", instr, 24'h001247);
    check("i2_len", instr_len, 2);
    check("i2_pc", instr_pc, 8'h01);
    wait_valid(w);
    check("lat_3byte", w, 7);
    check("i3_instr", instr, 24'h56348A);
    check("i3_len", instr_len, 3);
    check("i3_pc", instr_pc, 8'h03);
    check("abs_cycle", cyc - t0, 14);
    instr_ready = 1'b0;

    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", instr_valid, 1);
      check("hold_instr", instr, 24'h56348A);
      check("hold_len", instr_len, 3);
      check("hold_pc", instr_pc, 8'h03);
      check("hold_no_read", rom_read, 0);
    end
    instr_ready = 1'b1;
    step();
    check("resume_read", rom_read, 1);
    check("resume_addr", rom_address, 8'h06);

    step();
    rom_force_dly = 2;
    step();
    check("byte1_read", rom_read, 1);
    check("byte1_addr", rom_address, 8'h07);
    step();
    check("wait_no_read", rom_read, 0);
    issue_jump(8'h40);
    step();
    check("drain_no_read", rom_read, 0);
    step();
    check("drain2_no_read", rom_read, 0);
    step();
    check("jump_read", rom_read, 1);
    check("jump_addr", rom_address, 8'h40);
    wait_valid(w);
    check("jump_instr", instr, 24'h000015);
    check("jump_pc", instr_pc, 8'h40);
    instr_ready = 1'b0;

    rom[8'hFF] = 8'h47;
    rom[8'h00] = 8'h99;
    issue_jump(8'hFF);
    step();
    instr_ready = 1'b1;
    wait_valid(w);
    check("wrap_instr", instr, 24'h009947);
    check("wrap_pc", instr_pc, 8'hFF);
    check("wrap_len", instr_len, 2);
    check("wrap_next_pc", rom_address, 8'h01);

    rom[8'h00] = 8'h05;
    rom[8'h01] = 8'hEE;
    w = 0;
    do begin step(); w++; end while (!rom_read && w < 20);
    check("pre_rst_read", rom_read, 1);
    step();
    check("pre_rst_wait", rom_read, 0);
    rst_n = 1'b0;
    #1;
    check("rst_valid", instr_valid, 0);
    check("rst_instr", instr, 0);
    check("rst_addr", rom_address, 8'h00);
    restart_model(8'h00);
    step();
    for (int i = 1; i < 256; i++) rom[i] = 8'($urandom);
    step();
    rst_n = 1'b1;
    check("post_rst_read", rom_read, 1);
    check("post_rst_addr", rom_address, 8'h00);
    wait_valid(w);
    check("post_rst_instr", instr, 24'h000005);
    check("post_rst_lat", w, 2);

    rom_lat_max = 2;
    for (int i = 0; i < 3000; i++) begin
      step();
      instr_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 29) == 0) issue_jump(8'($urandom));
    end
    instr_ready = 1'b1;
    for (int i = 0; i < 30; i++) step();
    check("enough_accepted", (accepted > 150), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly downstream of the byte-wide program ROM.
- Issues single-byte ROM reads using the ROM's read/ready handshake.
- Assembles variable-length instructions of 1–3 bytes and presents them to the decoder through a valid/ready handshake.
- Supports a jump redirect from the execute stage that flushes any partial or in-flight fetch.

Parameters:
- size_addr, 8: ROM address / PC width.
- reset_pc, 0: PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- rom_read  out  1  ROM read strobe. High for exactly one cycle per byte.
- rom_address  out  size_addr  ROM byte address; equals the internal PC.
- rom_ready  in  1  ROM response strobe. The cycle after rom_read, rom_data is valid.
- rom_data  in  8  ROM read data.
- instr_valid  out  1  assembled instruction available.
- instr_ready  in  1  decoder accepts the instruction.
- instr  out  24  byte0 (opcode) at [7:0], operand1 at [15:8], operand2 at [23:16]. Unused bytes are zero.
- instr_len  out  2  instruction length in bytes, 1..3.
- instr_pc  out  size_addr  address of the opcode byte.
- jump  in  1  redirect request.
- jump_addr  in  size_addr  redirect target.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - State is S_REQ.
  - PC is reset_pc.
  - instr, instr_len, instr_pc and the byte index are all 0.
  - instr_valid is 0.
  - rom_read is 1 in the first cycle after release, since it is decoded from S_REQ.
- Length decode from opcode[7:6]: 00 gives 1 byte; 01 gives 2 bytes; 10 and 11 give 3 bytes.
- Outputs decoded from registers only:
  - rom_read is (state==S_REQ).
  - instr_valid is (state==S_HOLD).
  - rom_address is the PC register.
- S_REQ: rom_read=1 for one cycle, then go to S_WAIT.
- S_WAIT, rom_ready=0: stay in S_WAIT.
- S_WAIT, rom_ready=1: store rom_data into byte slot byte_idx, and increment the PC (wraps modulo 2^size_addr).
  - When byte_idx==0: clear instr, store the opcode, set instr_pc to the PC, and set instr_len from the length decode.
  - If byte_idx+1 < instr_len: increment byte_idx and go to S_REQ.
  - Otherwise: set byte_idx to 0 and go to S_HOLD.
- S_HOLD: instr, instr_len and instr_pc stay stable while instr_valid=1 and instr_ready=0.
  - On instr_ready=1, go to S_REQ.
- S_DRAIN: waits for the response of a read already issued to the ROM and discards its data.
  - On rom_ready=1, go to S_REQ.
- Jump (highest priority, any state):
  - PC takes jump_addr and byte_idx goes to 0.
  - In S_REQ the read is being issued, so go to S_DRAIN.
  - In S_WAIT with rom_ready=0, go to S_DRAIN.
  - In S_WAIT with rom_ready=1, discard the data and go to S_REQ.
  - In S_HOLD, go to S_REQ. If instr_ready is also 1, the held instruction counts as consumed.
  - In S_DRAIN with rom_ready=0, stay in S_DRAIN. With rom_ready=1, go to S_REQ.
  - A discarded byte never reaches instr.
- Only one ROM read is ever outstanding. rom_read is never asserted in S_WAIT or S_DRAIN.
- Latency: 2 cycles per byte.
  - After reset release, a 1-byte instruction is valid in cycle 2, and a 3-byte instruction in cycle 6.
  - Back-to-back 1-byte instructions with instr_ready tied high run at 3 cycles each.
- PC wrap: an instruction that straddles the top address continues at address 0.
- Reset mid-operation: immediate return to reset values. Any ROM response arriving after reset is ignored, because the state is S_REQ and rom_ready is not examined there.

Decomposition:
- Shared package lite_cpu_pkg holds:
  - state encoding: S_REQ, S_WAIT, S_HOLD, S_DRAIN;
  - the opcode length field position [7:6];
  - the function len_of(opcode).
- One natural sub-module, fetch_len_decode: combinational opcode to instr_len, reused later by the decoder.

Test Plan:
- ROM [0]=05: release reset with instr_ready=1. Expect:
  - rom_read in cycle 0, address 0;
  - instr_valid in cycle 2 with instr=000005, instr_len=1, instr_pc=00.
- ROM [1..2]=47,12 and [3..5]=8A,34,56: continue fetching from the first test. Expect:
  - instr=001247, len=2, pc=01;
  - then instr=56348A, len=3, pc=03.
- Hold with instr_ready=0 for 5 cycles in S_HOLD. Expect:
  - instr, len and pc stable;
  - no rom_read;
  - fetch resumes the cycle after instr_ready=1.
- Jump to 0x40 in S_WAIT with rom_ready=0, mid 3-byte instruction. Expect:
  - S_DRAIN, then the in-flight byte is discarded;
  - next rom_address is 40;
  - the next instr_pc is 40, containing ROM[40] only.
- size_addr=8, PC=FF, ROM[FF]=47, ROM[00]=99. Expect instr=009947 with pc=FF, after which the PC is 01.
- Assert rst_n=0 in S_WAIT while the ROM returns rom_ready=1. Expect:
  - instr_valid=0, instr=0;
  - the first post-reset rom_address is reset_pc;
  - the stale byte never appears in instr.
